// File: rtl/tpu_pkg.sv
// Shared TPU constants and the data-setup FSM state type.
// Combinational only; no latency.
// No flow control.
package tpu_pkg;
    localparam int DATA_W  = 8;
    localparam int ARRAY_N = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } setup_state_t;
endpackage

// File: rtl/systolic_data_setup_if.sv
// Activation-buffer to data-setup vector handshake.
// No logic, no latency.
// Standard valid/ready: the source holds its data while in_ready is low.
interface systolic_data_setup_if #(
    parameter int N      = tpu_pkg::ARRAY_N,
    parameter int DATA_W = tpu_pkg::DATA_W
);
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [DATA_W-1:0] in_data [N];

    modport master (output in_valid, in_data, in_last, input in_ready);
    modport slave  (input in_valid, in_data, in_last, output in_ready);
endinterface

// File: rtl/systolic_data_setup_skew_lane.sv
// DEPTH-stage shift register with zero reset; one skew lane.
// Latency DEPTH cycles.
// Never stalls; shifts every cycle.
module skew_lane #(
    parameter int DEPTH  = 1,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);
    logic [DATA_W-1:0] sr [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) sr[k] <= '0;
        end else begin
            sr[0] <= d;
            for (int k = 1; k < DEPTH; k++) sr[k] <= sr[k-1];
        end
    end

    assign q = sr[DEPTH-1];
endmodule

// File: rtl/systolic_data_setup.sv
// Skews activation vectors into the array's diagonal wavefront, zero-filling gaps.
// Lane i output lags the accept by i+1 cycles; done marks the last element leaving lane N-1.
// in_ready drops for N cycles after the last vector; the output side never stalls.
module systolic_data_setup #(
    parameter int N      = tpu_pkg::ARRAY_N,
    parameter int DATA_W = tpu_pkg::DATA_W
) (
    input  logic                   clk,
    input  logic                   reset,
    systolic_data_setup_if.slave   io,
    output logic [DATA_W-1:0]      left_out [N],
    output logic                   busy,
    output logic                   done
);
    import tpu_pkg::*;

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    setup_state_t      state;
    logic [CNT_W-1:0]  cnt;
    logic              acc;
    logic [DATA_W-1:0] lane_d [N];

    assign io.in_ready = (state != DRAIN);
    assign acc         = io.in_valid & io.in_ready;
    assign busy        = (state != IDLE);
    assign done        = (state == DRAIN) && (cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE, STREAM: begin
                    if (acc) begin
                        if (io.in_last) begin
                            state <= DRAIN;
                            cnt   <= CNT_W'(N - 1);
                        end else begin
                            state <= STREAM;
                        end
                    end
                end
                DRAIN: begin
                    if (cnt == '0) state <= IDLE;
                    else           cnt   <= cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Without an accept every lane takes a zero, so gaps become zero columns.
    always_comb begin
        for (int i = 0; i < N; i++) lane_d[i] = acc ? io.in_data[i] : '0;
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_lane #(
            .DEPTH  (i + 1),
            .DATA_W (DATA_W)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .d     (lane_d[i]),
            .q     (left_out[i])
        );
    end
endmodule

// File: tb/tb_systolic_data_setup.sv
// Directed cycle table for systolic_data_setup (N=4); scoreboard queue checked by a negedge monitor.
module tb_systolic_data_setup;
    localparam int N  = 4;
    localparam int DW = 8;

    typedef struct {
        int          idx;
        logic [31:0] out;
        logic        done;
        logic        busy;
        logic        rdy;
    } exp_t;

    typedef struct {
        logic        rst;
        logic        vld;
        logic        last;
        logic [31:0] din;
        logic [31:0] eout;
        logic        edone;
        logic        ebusy;
        logic        erdy;
    } row_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] left_out [N];
    logic          busy, done;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    row_t rows[$];

    systolic_data_setup_if #(.N(N), .DATA_W(DW)) bus ();

    systolic_data_setup #(.N(N), .DATA_W(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .io       (bus.slave),
        .left_out (left_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // din/eout pack lane 0 in the top byte: 32'h01020304 means lane0=1 .. lane3=4.
    task automatic add(input logic rst, input logic vld, input logic last,
                       input logic [31:0] din, input logic [31:0] eout,
                       input logic edone, input logic ebusy, input logic erdy);
        row_t r;
        r.rst = rst; r.vld = vld; r.last = last; r.din = din; r.eout = eout;
        r.edone = edone; r.ebusy = ebusy; r.erdy = erdy;
        rows.push_back(r);
    endtask

    task automatic build_table();
        // Reset state, then single vector with last accepted at c0.
        add(0,0,0,32'hEEEEEEEE, 32'h00000000, 0,0,1);
        add(0,1,1,32'h01020304, 32'h00000000, 0,0,1);
        add(0,0,0,32'hEEEEEEEE, 32'h01000000, 0,1,0);
        add(0,0,0,32'hEEEEEEEE, 32'h00020000, 0,1,0);
        add(0,0,0,32'hEEEEEEEE, 32'h00000300, 0,1,0);
        add(0,0,0,32'hEEEEEEEE, 32'h00000004, 1,1,0);
        add(0,0,0,32'hEEEEEEEE, 32'h00000000, 0,0,1);
        // Three back-to-back vectors A, B, C(last).
        add(0,1,0,32'h01010101, 32'h00000000, 0,0,1);
        add(0,1,0,32'h02020202, 32'h01000000, 0,1,1);
        add(0,1,1,32'h03030303, 32'h02010000, 0,1,1);
        add(0,0,1,32'hEEEEEEEE, 32'h03020100, 0,1,0);
        add(0,0,0,32'hEEEEEEEE, 32'h00030201, 0,1,0);
        add(0,0,0,32'hEEEEEEEE, 32'h00000302, 0,1,0);
        add(0,0,0,32'hEEEEEEEE, 32'h00000003, 1,1,0);
        add(0,0,0,32'hEEEEEEEE, 32'h00000000, 0,0,1);
        // Bubble between A and B(last).
        add(0,1,0,32'h0A0B0C0D, 32'h00000000, 0,0,1);
        add(0,0,1,32'hEEEEEEEE, 32'h0A000000, 0,1,1);
        add(0,1,1,32'h1A1B1C1D, 32'h000B0000, 0,1,1);
        add(0,0,0,32'hEEEEEEEE, 32'h1A000C00, 0,1,0);
        add(0,0,0,32'hEEEEEEEE, 32'h001B000D, 0,1,0);
        add(0,0,0,32'hEEEEEEEE, 32'h00001C00, 0,1,0);
        add(0,0,0,32'hEEEEEEEE, 32'h0000001D, 1,1,0);
        add(0,0,0,32'hEEEEEEEE, 32'h00000000, 0,0,1);
        // D held valid through DRAIN; accepted only in the first IDLE cycle.
        add(0,1,1,32'h01020304, 32'h00000000, 0,0,1);
        add(0,1,1,32'h09090909, 32'h01000000, 0,1,0);
        add(0,1,1,32'h09090909, 32'h00020000, 0,1,0);
        add(0,1,1,32'h09090909, 32'h00000300, 0,1,0);
        add(0,1,1,32'h09090909, 32'h00000004, 1,1,0);
        add(0,1,1,32'h09090909, 32'h00000000, 0,0,1);
        add(0,0,0,32'hEEEEEEEE, 32'h09000000, 0,1,0);
        add(0,0,0,32'hEEEEEEEE, 32'h00090000, 0,1,0);
        add(0,0,0,32'hEEEEEEEE, 32'h00000900, 0,1,0);
        add(0,0,0,32'hEEEEEEEE, 32'h00000009, 1,1,0);
        add(0,0,0,32'hEEEEEEEE, 32'h00000000, 0,0,1);
        // Reset in c2 of a single-vector stream.
        add(0,1,1,32'h01020304, 32'h00000000, 0,0,1);
        add(0,0,0,32'hEEEEEEEE, 32'h01000000, 0,1,0);
        add(1,0,0,32'hEEEEEEEE, 32'h00020000, 0,1,0);
        add(0,0,0,32'hEEEEEEEE, 32'h00000000, 0,0,1);
        add(0,0,0,32'hEEEEEEEE, 32'h00000000, 0,0,1);
        add(0,0,0,32'hEEEEEEEE, 32'h00000000, 0,0,1);
        // Reset mid-stream, then ten idle cycles with ignored garbage on the bus.
        add(0,1,0,32'h05060708, 32'h00000000, 0,0,1);
        add(1,1,0,32'h05060708, 32'h05000000, 0,1,1);
        for (int k = 0; k < 10; k++)
            add(0,0,k[0],32'hFFFFFFFF, 32'h00000000, 0,0,1);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e   = sb.pop_front();
            act = {left_out[0], left_out[1], left_out[2], left_out[3]};
            tests++;
            if (act !== e.out) begin
                fails++;
                $display("FAIL row%0d left_out: got %08h expected %08h", e.idx, act, e.out);
            end
            tests++;
            if (done !== e.done) begin
                fails++;
                $display("FAIL row%0d done: got %b expected %b", e.idx, done, e.done);
            end
            tests++;
            if (busy !== e.busy) begin
                fails++;
                $display("FAIL row%0d busy: got %b expected %b", e.idx, busy, e.busy);
            end
            tests++;
            if (bus.in_ready !== e.rdy) begin
                fails++;
                $display("FAIL row%0d in_ready: got %b expected %b", e.idx, bus.in_ready, e.rdy);
            end
        end
    end

    initial begin
        int guard;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        for (int i = 0; i < N; i++) bus.in_data[i] = '0;
        build_table();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        for (int r = 0; r < rows.size(); r++) begin
            exp_t e;
            #1;
            reset        = rows[r].rst;
            bus.in_valid = rows[r].vld;
            bus.in_last  = rows[r].last;
            for (int i = 0; i < N; i++) bus.in_data[i] = rows[r].din[31-8*i -: 8];
            e.idx  = r;
            e.out  = rows[r].eout;
            e.done = rows[r].edone;
            e.busy = rows[r].ebusy;
            e.rdy  = rows[r].erdy;
            sb.push_back(e);
            @(posedge clk);
        end
        #1;
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
